// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state type and sizing helper for the word serializer
package serializer_pkg;

  typedef enum logic {IDLE, SHIFT} serstate_t;

  // Beat counter width; never narrower than one bit so NBEATS==1 still has a counter.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shiftloadreg.sv
// rtl/shiftloadreg.sv - parallel-load right-shift register, load wins over shift
module shiftloadreg #(
  parameter int WIDTH = 64,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic [SHIFT-1:0] low
);

  logic [WIDTH-1:0] data;

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= data >> SHIFT;
    end
  end

  assign low = data[SHIFT-1:0];

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel word in, LSB-first beats out on valid/ready handshakes
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BEAT  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [BEAT-1:0]  OutData,
  output logic             OutLast,
  output logic             Busy
);

  localparam int NBEATS = WIDTH / BEAT;
  localparam int CW     = cnt_width(NBEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  if (WIDTH % BEAT != 0) begin : g_bad_width
    $error("word_serializer: WIDTH must be a multiple of BEAT");
  end

  serstate_t       state, state_next;
  logic [CW-1:0]   beat_cnt, beat_cnt_next;
  logic [BEAT-1:0] sh_low;
  logic            is_last, fire_out, capture, shift_en;

  assign is_last  = (beat_cnt == LAST_BEAT);
  assign OutValid = !reset && (state == SHIFT);
  assign Busy     = OutValid;
  assign OutLast  = OutValid && is_last;
  assign OutData  = OutValid ? sh_low : '0;
  assign fire_out = OutValid && OutReady;

  // Accept a new word on the last-beat edge so back-to-back words leave no bubble.
  assign InReady  = !reset && !Flush && ((state == IDLE) || (fire_out && is_last));
  assign capture  = InValid && InReady;
  assign shift_en = fire_out && !is_last && !Flush;

  shiftloadreg #(
    .WIDTH(WIDTH),
    .SHIFT(BEAT)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (capture),
    .load_data(InData),
    .shift_en (shift_en),
    .low      (sh_low)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    if (Flush) begin
      state_next    = IDLE;
      beat_cnt_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (capture) begin
            state_next    = SHIFT;
            beat_cnt_next = '0;
          end
        end
        SHIFT: begin
          if (fire_out) begin
            if (is_last) begin
              beat_cnt_next = '0;
              state_next    = capture ? SHIFT : IDLE;
            end else begin
              beat_cnt_next = beat_cnt + CW'(1);
            end
          end
        end
        default: begin
          state_next    = IDLE;
          beat_cnt_next = '0;
        end
      endcase
    end
  end

endmodule
